mha_softmax_path_arbiter: RTL and testbench
===========================================

# mha_softmax_path_arbiter

Round-robin scheduler that shares a single softmax bank + R2B converter path between NUM_HEADS self-attention heads in the multi-head attention block. Grants one head at a time for one complete score slice and steers that head's tile beats into the shared path with row/tile indices. Waits for the path to drain and issues the path's internal reset pulse before re-arbitrating. One instance sits between the per-head Q·Kᵀ/B2R stages and the shared softmax/R2B stage.

## Interface
- NUM_HEADS, 4, number of requesting heads (≥2)
- ROWS_PER_SLICE, 4, softmax rows per slice (NUM_CORES × BLOCK_SIZE upstream)
- TILES_PER_ROW, 2, softmax tiles per row
- Derived: HW = max(1,$clog2(NUM_HEADS)), RW = max(1,$clog2(ROWS_PER_SLICE)), TW = max(1,$clog2(TILES_PER_ROW)), BEATS = ROWS_PER_SLICE × TILES_PER_ROW

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- head_req  in  NUM_HEADS  head i has a full slice ready; held high until head_done[i]
- head_beat_valid  in  NUM_HEADS  head i presents a tile beat
- head_beat_ready  out  NUM_HEADS  beat of head i accepted this cycle
- path_valid  out  1  beat presented to shared path
- path_ready  in  1  shared path accepts beat
- path_sel  out  HW  index of granted head (data mux select)
- path_row_idx  out  RW  row of current beat
- path_tile_idx  out  TW  tile of current beat
- path_last  out  1  current beat is beat BEATS-1 of slice
- path_done  in  1  shared path finished slice (softmax done and R2B flushed)
- path_rst_n  out  1  internal reset of shared path, active-low
- head_done  out  NUM_HEADS  one-cycle pulse, slice of head i complete
- busy  out  1  state ≠ IDLE
- err  out  1  sticky protocol error

## Operation
- States: IDLE, STREAM, DRAIN, FLUSH.
- IDLE: if |head_req, pick first requesting head at or after rr_ptr (wrapping modulo NUM_HEADS); register gidx, row=0, tile=0; -> STREAM. Else stay.
- STREAM: path_valid = head_beat_valid[gidx]; head_beat_ready[i] = (i==gidx) & path_ready; other ready bits 0. Transfer = path_valid & path_ready.
- Beat order: row fastest; on transfer row++; when row == ROWS_PER_SLICE-1, row<=0 and tile++. path_last = (row==ROWS_PER_SLICE-1)&(tile==TILES_PER_ROW-1).
- Transfer with path_last -> DRAIN; row, tile <= 0.
- DRAIN: path_valid 0; wait path_done; -> FLUSH.
- FLUSH (exactly 1 cycle): path_rst_n low, head_done[gidx] high, rr_ptr <= (gidx+1) mod NUM_HEADS; -> IDLE.
- Grant held for the whole slice; head_req changes during STREAM/DRAIN are ignored (no abort).
- err set (sticky, cleared only by reset) when: path_done high outside DRAIN (ignored otherwise); or head_req[gidx] low during STREAM.
- path_sel = gidx in every state; gidx holds its value through IDLE.

## Timing
- Reset (rst_n low at clk edge): state IDLE, gidx 0, rr_ptr 0, row/tile 0, err 0, head_done 0, path_rst_n 0 (follows rst_n), hence path_valid 0, head_beat_ready 0, busy 0, path_last 0.
- Reset mid-slice: immediate abort to IDLE; no head_done; path_rst_n low during reset and high first cycle after.
- Grant latency: head_req sampled high in IDLE at edge N -> STREAM at N+1; first beat can transfer in cycle N+1.
- Minimum slice: 1 (IDLE) + BEATS (STREAM, path_ready and valid continuous) + ≥1 (DRAIN) + 1 (FLUSH) cycles.
- path_done in same cycle as entering DRAIN is not seen (sampled from first DRAIN cycle on).
- path_valid/head_beat_ready/path_last are combinational from registered state and inputs; all other outputs registered.
- path_rst_n registered: low exactly in FLUSH cycle, otherwise high (outside reset).

## Test plan
- Single head: NUM_HEADS=4, head_req=0b0001, continuous valid/ready, path_done 2 cycles after last beat -> 8 beats with (row,tile) (0,0)(1,0)(2,0)(3,0)(0,1)…(3,1), path_last on beat 8 only, head_done[0] pulse, path_rst_n low 1 cycle.
- Round-robin: head_req=0b1111 held -> grant order 0,1,2,3,0; rr wraps from 3 to 0.
- Backpressure: path_ready toggled 1,0,1,0 and head_beat_valid gaps -> exactly 8 transfers, indices advance only on transfers, no beat duplicated or lost.
- Stray done: path_done pulsed during STREAM -> ignored, err=1 and stays 1 until reset; slice still completes normally.
- Reset mid-slice: rst_n low after beat 3 -> all outputs at reset values, next slice restarts at (0,0) with head 0 granted.
- Early req drop: head_req[gidx] cleared during STREAM -> err=1, grant held, slice completes with head_done pulse.

Source files
------------

// File: rtl/mha_softmax_path_arbiter.sv
// Round-robin arbiter sharing one softmax + R2B path between attention heads.
// A head holds the grant for a whole slice; the path is drained and reset before re-arbitration.
module mha_softmax_path_arbiter #(
  parameter int NUM_HEADS      = 4,
  parameter int ROWS_PER_SLICE = 4,
  parameter int TILES_PER_ROW  = 2,
  localparam int HW = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1,
  localparam int RW = (ROWS_PER_SLICE > 1) ? $clog2(ROWS_PER_SLICE) : 1,
  localparam int TW = (TILES_PER_ROW > 1) ? $clog2(TILES_PER_ROW) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_HEADS-1:0] head_req,
  input  logic [NUM_HEADS-1:0] head_beat_valid,
  output logic [NUM_HEADS-1:0] head_beat_ready,
  output logic                 path_valid,
  input  logic                 path_ready,
  output logic [HW-1:0]        path_sel,
  output logic [RW-1:0]        path_row_idx,
  output logic [TW-1:0]        path_tile_idx,
  output logic                 path_last,
  input  logic                 path_done,
  output logic                 path_rst_n,
  output logic [NUM_HEADS-1:0] head_done,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FLUSH} state_t;

  localparam logic [RW-1:0]        ROW_LAST  = RW'(ROWS_PER_SLICE - 1);
  localparam logic [TW-1:0]        TILE_LAST = TW'(TILES_PER_ROW - 1);
  localparam logic [HW-1:0]        HEAD_LAST = HW'(NUM_HEADS - 1);
  localparam logic [NUM_HEADS-1:0] HEAD_ONE  = {{(NUM_HEADS-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [HW-1:0]        gidx_q, gidx_d;
  logic [HW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [RW-1:0]        row_q, row_d;
  logic [TW-1:0]        tile_q, tile_d;
  logic                 err_q, err_d;
  logic [NUM_HEADS-1:0] head_done_q, head_done_d;
  logic                 path_rst_n_q, path_rst_n_d;

  logic                 pick_found;
  logic [HW-1:0]        pick_idx;
  logic                 xfer;
  logic                 last_beat;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    int c;
    c          = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_HEADS; k++) begin
      c = int'(rr_ptr_q) + k;
      if (c >= NUM_HEADS) c = c - NUM_HEADS;
      if (!pick_found && head_req[c]) begin
        pick_found = 1'b1;
        pick_idx   = HW'(c);
      end
    end
  end

  assign last_beat       = (row_q == ROW_LAST) && (tile_q == TILE_LAST);
  assign path_valid      = (state_q == STREAM) && head_beat_valid[gidx_q];
  assign head_beat_ready = ((state_q == STREAM) && path_ready) ? (HEAD_ONE << gidx_q) : '0;
  assign xfer            = path_valid && path_ready;
  assign path_last       = (state_q == STREAM) && last_beat;

  always_comb begin
    state_d  = state_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    row_d    = row_q;
    tile_d   = tile_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gidx_d  = pick_idx;
          row_d   = '0;
          tile_d  = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (last_beat) begin
            row_d   = '0;
            tile_d  = '0;
            state_d = DRAIN;
          end else if (row_q == ROW_LAST) begin
            row_d  = '0;
            tile_d = tile_q + TW'(1);
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      DRAIN: begin
        if (path_done) state_d = FLUSH;
      end
      FLUSH: begin
        rr_ptr_d = (gidx_q == HEAD_LAST) ? '0 : gidx_q + HW'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stray completions and a granted head withdrawing its request are both latched.
  always_comb begin
    err_d        = err_q
                 | (path_done && (state_q != DRAIN))
                 | ((state_q == STREAM) && !head_req[gidx_q]);
    head_done_d  = (state_d == FLUSH) ? (HEAD_ONE << gidx_q) : '0;
    path_rst_n_d = (state_d != FLUSH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gidx_q       <= '0;
      rr_ptr_q     <= '0;
      row_q        <= '0;
      tile_q       <= '0;
      err_q        <= 1'b0;
      head_done_q  <= '0;
      path_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gidx_q       <= gidx_d;
      rr_ptr_q     <= rr_ptr_d;
      row_q        <= row_d;
      tile_q       <= tile_d;
      err_q        <= err_d;
      head_done_q  <= head_done_d;
      path_rst_n_q <= path_rst_n_d;
    end
  end

  assign path_sel      = gidx_q;
  assign path_row_idx  = row_q;
  assign path_tile_idx = tile_q;
  assign path_rst_n    = path_rst_n_q;
  assign head_done     = head_done_q;
  assign busy          = (state_q != IDLE);
  assign err           = err_q;

endmodule

// File: tb/tb_mha_softmax_path_arbiter.sv
// Directed table-driven bench for mha_softmax_path_arbiter (4 heads, 4 rows x 2 tiles).
module tb_mha_softmax_path_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] head_req;
  logic [3:0] head_beat_valid;
  logic [3:0] head_beat_ready;
  logic       path_valid;
  logic       path_ready;
  logic [1:0] path_sel;
  logic [1:0] path_row_idx;
  logic       path_tile_idx;
  logic       path_last;
  logic       path_done;
  logic       path_rst_n;
  logic [3:0] head_done;
  logic       busy;
  logic       err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mha_softmax_path_arbiter #(
    .NUM_HEADS(4), .ROWS_PER_SLICE(4), .TILES_PER_ROW(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .head_req(head_req),
    .head_beat_valid(head_beat_valid), .head_beat_ready(head_beat_ready),
    .path_valid(path_valid), .path_ready(path_ready), .path_sel(path_sel),
    .path_row_idx(path_row_idx), .path_tile_idx(path_tile_idx),
    .path_last(path_last), .path_done(path_done), .path_rst_n(path_rst_n),
    .head_done(head_done), .busy(busy), .err(err)
  );

  typedef struct {
    logic [3:0] req;
    logic [7:0] rdy;
    logic [7:0] vld;
    int         dly;
    int         stray;
    int         drop;
    logic [1:0] grant;
    logic       exp_err;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " path_valid"}, 32'(path_valid), 0);
    chk({tag, " head_beat_ready"}, 32'(head_beat_ready), 0);
    chk({tag, " path_rst_n"}, 32'(path_rst_n), 0);
    chk({tag, " head_done"}, 32'(head_done), 0);
    chk({tag, " err"}, 32'(err), 0);
    chk({tag, " path_sel"}, 32'(path_sel), 0);
    chk({tag, " row"}, 32'(path_row_idx), 0);
    chk({tag, " tile"}, 32'(path_tile_idx), 0);
    chk({tag, " path_last"}, 32'(path_last), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0; head_req = '0; head_beat_valid = '0; path_ready = 1'b0; path_done = 1'b0;
    @(negedge clk);
    check_reset_outputs(tag);
    rst_n = 1'b1;
    @(negedge clk);
    chk({tag, " path_rst_n after release"}, 32'(path_rst_n), 1);
  endtask

  task automatic run_slice(input vec_t v, input int id);
    int         beats;
    int         cyc;
    logic [3:0] oh;
    string      t;
    t  = $sformatf("slice%0d", id);
    oh = 4'b0001 << v.grant;
    @(negedge clk);
    head_req = v.req; head_beat_valid = '0; path_ready = 1'b0;
    @(negedge clk);
    chk({t, " busy"}, 32'(busy), 1);
    chk({t, " grant"}, 32'(path_sel), 32'(v.grant));
    beats = 0;
    cyc   = 0;
    while (beats < 8 && cyc < 100) begin
      path_ready      = v.rdy[cyc % 8];
      head_beat_valid = {4{v.vld[cyc % 8]}};
      path_done       = (cyc == v.stray);
      if (cyc == v.drop) head_req = v.req & ~oh;
      #1;
      chk({t, " ready"}, 32'(head_beat_ready), path_ready ? 32'(oh) : 0);
      chk({t, " valid"}, 32'(path_valid), 32'(v.vld[cyc % 8]));
      if (path_valid && path_ready) begin
        chk({t, " row"}, 32'(path_row_idx), beats % 4);
        chk({t, " tile"}, 32'(path_tile_idx), beats / 4);
        chk({t, " last"}, 32'(path_last), (beats == 7) ? 1 : 0);
        beats++;
      end
      @(negedge clk);
      cyc++;
    end
    chk({t, " transfers before timeout"}, 32'(beats), 8);
    path_done = 1'b0; head_beat_valid = '1; path_ready = 1'b1;
    #1;
    chk({t, " drain valid"}, 32'(path_valid), 0);
    chk({t, " drain ready"}, 32'(head_beat_ready), 0);
    chk({t, " drain head_done"}, 32'(head_done), 0);
    for (int i = 1; i < v.dly; i++) @(negedge clk);
    path_done = 1'b1;
    @(negedge clk);
    path_done = 1'b0;
    chk({t, " flush head_done"}, 32'(head_done), 32'(oh));
    chk({t, " flush path_rst_n"}, 32'(path_rst_n), 0);
    head_req = '0; head_beat_valid = '0; path_ready = 1'b0;
    @(negedge clk);
    chk({t, " idle head_done"}, 32'(head_done), 0);
    chk({t, " idle path_rst_n"}, 32'(path_rst_n), 1);
    chk({t, " idle busy"}, 32'(busy), 0);
    chk({t, " err"}, 32'(err), 32'(v.exp_err));
  endtask

  initial begin
    vec_t v;
    vt[0]  = '{4'b0001, 8'hFF, 8'hFF, 2, -1, -1, 2'd0, 1'b0};
    vt[1]  = '{4'b1111, 8'hFF, 8'hFF, 2, -1, -1, 2'd1, 1'b0};
    vt[2]  = '{4'b1111, 8'hFF, 8'hFF, 2, -1, -1, 2'd2, 1'b0};
    vt[3]  = '{4'b1111, 8'hFF, 8'hFF, 2, -1, -1, 2'd3, 1'b0};
    vt[4]  = '{4'b1111, 8'hFF, 8'hFF, 2, -1, -1, 2'd0, 1'b0};
    vt[5]  = '{4'b0100, 8'hFF, 8'hFF, 3, -1, -1, 2'd2, 1'b0};
    vt[6]  = '{4'b1001, 8'hFF, 8'hFF, 1, -1, -1, 2'd3, 1'b0};
    vt[7]  = '{4'b0011, 8'b01010101, 8'b10110111, 2, -1, -1, 2'd0, 1'b0};
    vt[8]  = '{4'b0110, 8'hFF, 8'b11011011, 2, -1, -1, 2'd1, 1'b0};
    vt[9]  = '{4'b1000, 8'hFF, 8'hFF, 2, 2, -1, 2'd3, 1'b1};
    vt[10] = '{4'b0101, 8'hFF, 8'hFF, 2, -1, 3, 2'd0, 1'b1};

    rst_n = 1'b0; head_req = '0; head_beat_valid = '0; path_ready = 1'b0; path_done = 1'b0;
    do_reset("reset");

    for (int i = 0; i < 11; i++) run_slice(vt[i], i);

    // Error flag must survive idle cycles and clear only on reset.
    @(negedge clk);
    chk("err sticky", 32'(err), 1);
    do_reset("reset2");

    v = '{4'b0001, 8'hFF, 8'hFF, 2, -1, -1, 2'd0, 1'b0};
    run_slice(v, 11);

    // Mid-slice reset on head 1 after three beats.
    @(negedge clk);
    head_req = 4'hF; head_beat_valid = 4'hF; path_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mid grant", 32'(path_sel), 1);
    chk("mid row", 32'(path_row_idx), 3);
    chk("mid tile", 32'(path_tile_idx), 0);
    rst_n = 1'b0; head_req = '0; head_beat_valid = '0; path_ready = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid path_rst_n after release", 32'(path_rst_n), 1);

    v = '{4'b1111, 8'hFF, 8'hFF, 2, -1, -1, 2'd0, 1'b0};
    run_slice(v, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
